// File: rtl/lcd_sched_pkg.sv
// rtl/lcd_sched_pkg.sv - shared types, LCD command codes and ASCII constants for the text scheduler
//
// Purpose: FSM state encoding plus the HD44780-style command bytes and the
// control characters the scheduler recognises. No ports (package).
package lcd_sched_pkg;

  typedef enum logic [3:0] {
    INIT_CLR,
    IDLE,
    DECODE,
    WIPE,
    SETADDR,
    WRDATA,
    BS_ADDR1,
    BS_SPACE,
    BS_ADDR2
  } sched_state_t;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_SETADDR = 8'h80;
  localparam logic [7:0] ROW1_BASE   = 8'h40;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_ESC   = 8'h1B;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_MIN   = 8'h20;
  localparam logic [7:0] ASCII_MAX   = 8'h7E;

  localparam int LCD_ROWS = 2;

  // DDRAM address command: row 1 starts at 0x40 on a two-line display.
  function automatic logic [7:0] setaddr_cmd(input logic row, input logic [3:0] col);
    return CMD_SETADDR | (row ? ROW1_BASE : 8'h00) | {4'h0, col};
  endfunction

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= ASCII_MIN) && (c <= ASCII_MAX);
  endfunction

endpackage

// File: rtl/char_fifo.sv
// rtl/char_fifo.sv - small synchronous FIFO buffering incoming characters
//
// Purpose: show-ahead FIFO (rd_data is the head entry whenever !empty).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   wr_en, wr_data  write strobe and data (ignored while full)
//   rd_en           pop the head entry (ignored while empty)
//   rd_data         head entry
//   full, empty     occupancy flags
module char_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/lcd_text_scheduler.sv
// rtl/lcd_text_scheduler.sv - turns buffered ASCII into LCD command/data transfers on a 16x2 display
//
// Purpose: buffers characters, tracks the cursor and sequences LCD transfers,
// handling Enter, Backspace, Esc and a wipe when the screen fills.
// Ports:
//   clk50, reset              50 MHz clock, asynchronous active-low reset
//   ascii_vld, ascii_data     one-cycle character strobe and code
//   lcd_vld, lcd_rs, lcd_byte transfer request (rs=0 command, rs=1 data)
//   lcd_ready                 driver accepts when high
//   cursor_row, cursor_col    current cursor position
//   busy                      work pending (FSM active or FIFO not empty)
//   overflow                  sticky: a character was dropped on a full FIFO
module lcd_text_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LCD_COLS   = 16
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       ascii_vld,
  input  logic [7:0] ascii_data,
  output logic       lcd_vld,
  output logic       lcd_rs,
  output logic [7:0] lcd_byte,
  input  logic       lcd_ready,
  output logic       cursor_row,
  output logic [3:0] cursor_col,
  output logic       busy,
  output logic       overflow
);

  localparam logic [3:0] LAST_COL = 4'(LCD_COLS - 1);
  localparam logic       LAST_ROW = 1'(LCD_ROWS - 1);

  sched_state_t state, state_n;
  logic [7:0]   cur_char, cur_char_n;
  logic         row_n;
  logic [3:0]   col_n;
  logic         addr_sync, addr_sync_n;     // LCD address counter matches the cursor
  logic         wipe_pending, wipe_pending_n;
  logic         wipe_esc, wipe_esc_n;       // WIPE entered by Esc: no character follows
  logic         tgt_row, tgt_row_n;
  logic [3:0]   tgt_col, tgt_col_n;
  logic         lcd_vld_n, lcd_rs_n;
  logic [7:0]   lcd_byte_n;

  logic         fifo_pop, fifo_full, fifo_empty;
  logic [7:0]   fifo_rdata;
  logic         xfer_done;

  assign xfer_done = lcd_vld && lcd_ready;

  char_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk    (clk50),
    .rst_n  (reset),
    .wr_en  (ascii_vld),
    .wr_data(ascii_data),
    .rd_en  (fifo_pop),
    .rd_data(fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_n        = state;
    cur_char_n     = cur_char;
    row_n          = cursor_row;
    col_n          = cursor_col;
    addr_sync_n    = addr_sync;
    wipe_pending_n = wipe_pending;
    wipe_esc_n     = wipe_esc;
    tgt_row_n      = tgt_row;
    tgt_col_n      = tgt_col;
    fifo_pop       = 1'b0;
    lcd_vld_n      = 1'b0;
    lcd_rs_n       = lcd_rs;
    lcd_byte_n     = lcd_byte;

    case (state)
      INIT_CLR: if (xfer_done) state_n = IDLE;
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          cur_char_n = fifo_rdata;
          state_n    = DECODE;
        end
      end
      DECODE: begin
        if (is_printable(cur_char)) begin
          if (wipe_pending) begin
            wipe_esc_n = 1'b0;
            state_n    = WIPE;
          end else if (!addr_sync) begin
            state_n = SETADDR;
          end else begin
            state_n = WRDATA;
          end
        end else if (cur_char == ASCII_CR) begin
          state_n = IDLE;
          if (cursor_row != LAST_ROW) begin
            row_n       = LAST_ROW;
            col_n       = 4'd0;
            addr_sync_n = 1'b0;
          end else begin
            wipe_pending_n = 1'b1;
          end
        end else if (cur_char == ASCII_BS) begin
          state_n = BS_ADDR1;
          if (wipe_pending) begin
            // Screen full and cursor parked at home: erase the last cell.
            wipe_pending_n = 1'b0;
            tgt_row_n      = LAST_ROW;
            tgt_col_n      = LAST_COL;
          end else if (cursor_col != 4'd0) begin
            tgt_row_n = cursor_row;
            tgt_col_n = cursor_col - 4'd1;
          end else if (cursor_row != 1'b0) begin
            tgt_row_n = 1'b0;
            tgt_col_n = LAST_COL;
          end else begin
            state_n = IDLE;
          end
        end else if (cur_char == ASCII_ESC) begin
          wipe_esc_n = 1'b1;
          state_n    = WIPE;
        end else begin
          state_n = IDLE;
        end
      end
      WIPE: begin
        if (xfer_done) begin
          row_n          = 1'b0;
          col_n          = 4'd0;
          addr_sync_n    = 1'b1;
          wipe_pending_n = 1'b0;
          state_n        = wipe_esc ? IDLE : WRDATA;
        end
      end
      SETADDR: begin
        if (xfer_done) begin
          addr_sync_n = 1'b1;
          state_n     = WRDATA;
        end
      end
      WRDATA: begin
        if (xfer_done) begin
          state_n = IDLE;
          if (cursor_col != LAST_COL) begin
            col_n = cursor_col + 4'd1;
          end else if (cursor_row != LAST_ROW) begin
            // The LCD address counter does not jump to 0x40 on its own.
            row_n       = LAST_ROW;
            col_n       = 4'd0;
            addr_sync_n = 1'b0;
          end else begin
            row_n          = 1'b0;
            col_n          = 4'd0;
            wipe_pending_n = 1'b1;
          end
        end
      end
      BS_ADDR1: if (xfer_done) state_n = BS_SPACE;
      BS_SPACE: if (xfer_done) state_n = BS_ADDR2;
      BS_ADDR2: begin
        if (xfer_done) begin
          row_n       = tgt_row;
          col_n       = tgt_col;
          addr_sync_n = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = INIT_CLR;
    endcase

    // Transfer outputs follow the state being entered so that a new transfer
    // starts on the same edge the previous one completes; while waiting the
    // state and its operands are unchanged, so the request stays stable.
    case (state_n)
      INIT_CLR, WIPE: begin
        lcd_vld_n  = 1'b1;
        lcd_rs_n   = 1'b0;
        lcd_byte_n = CMD_CLEAR;
      end
      SETADDR: begin
        lcd_vld_n  = 1'b1;
        lcd_rs_n   = 1'b0;
        lcd_byte_n = setaddr_cmd(row_n, col_n);
      end
      WRDATA: begin
        lcd_vld_n  = 1'b1;
        lcd_rs_n   = 1'b1;
        lcd_byte_n = cur_char_n;
      end
      BS_ADDR1, BS_ADDR2: begin
        lcd_vld_n  = 1'b1;
        lcd_rs_n   = 1'b0;
        lcd_byte_n = setaddr_cmd(tgt_row_n, tgt_col_n);
      end
      BS_SPACE: begin
        lcd_vld_n  = 1'b1;
        lcd_rs_n   = 1'b1;
        lcd_byte_n = ASCII_SPACE;
      end
      default: lcd_vld_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      state        <= INIT_CLR;
      cur_char     <= 8'h00;
      cursor_row   <= 1'b0;
      cursor_col   <= 4'd0;
      addr_sync    <= 1'b1;
      wipe_pending <= 1'b0;
      wipe_esc     <= 1'b0;
      tgt_row      <= 1'b0;
      tgt_col      <= 4'd0;
      lcd_vld      <= 1'b0;
      lcd_rs       <= 1'b0;
      lcd_byte     <= 8'h00;
      busy         <= 1'b1;
      overflow     <= 1'b0;
    end else begin
      state        <= state_n;
      cur_char     <= cur_char_n;
      cursor_row   <= row_n;
      cursor_col   <= col_n;
      addr_sync    <= addr_sync_n;
      wipe_pending <= wipe_pending_n;
      wipe_esc     <= wipe_esc_n;
      tgt_row      <= tgt_row_n;
      tgt_col      <= tgt_col_n;
      lcd_vld      <= lcd_vld_n;
      lcd_rs       <= lcd_rs_n;
      lcd_byte     <= lcd_byte_n;
      busy         <= (state != IDLE) || !fifo_empty;
      if (ascii_vld && fifo_full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_text_scheduler.sv
// tb/tb_lcd_text_scheduler.sv - directed scoreboard bench for lcd_text_scheduler
module tb_lcd_text_scheduler;

  logic       clk50 = 1'b0;
  logic       reset = 1'b0;
  logic       ascii_vld = 1'b0;
  logic [7:0] ascii_data = 8'h00;
  logic       lcd_ready = 1'b1;
  logic       lcd_vld, lcd_rs;
  logic [7:0] lcd_byte;
  logic       cursor_row;
  logic [3:0] cursor_col;
  logic       busy, overflow;

  int         n_assert = 0;
  int         n_fail = 0;
  int         n_xfer = 0;
  logic [8:0] exp_q[$];
  logic       hold_pending = 1'b0;
  logic [8:0] hold_word = 9'h0;

  always #5 clk50 = ~clk50;

  lcd_text_scheduler #(
    .FIFO_DEPTH(4),
    .LCD_COLS  (16)
  ) dut (
    .clk50     (clk50),
    .reset     (reset),
    .ascii_vld (ascii_vld),
    .ascii_data(ascii_data),
    .lcd_vld   (lcd_vld),
    .lcd_rs    (lcd_rs),
    .lcd_byte  (lcd_byte),
    .lcd_ready (lcd_ready),
    .cursor_row(cursor_row),
    .cursor_col(cursor_col),
    .busy      (busy),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every completed handshake pops one expected {rs,byte};
  // a stalled request must hold its value until accepted.
  always @(negedge clk50) begin
    if (!reset) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_vld", lcd_vld, 1);
        check("hold_word", {lcd_rs, lcd_byte}, hold_word);
      end
      hold_pending = lcd_vld && !lcd_ready;
      hold_word    = {lcd_rs, lcd_byte};
      if (lcd_vld && lcd_ready) begin
        n_xfer++;
        n_assert++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_xfer observed=0x%0h expected=none", {lcd_rs, lcd_byte});
        end
        if (exp_q.size() != 0) check("xfer_word", {lcd_rs, lcd_byte}, exp_q.pop_front());
      end
    end
  end

  task automatic expect_xfer(input logic rs, input logic [7:0] b);
    exp_q.push_back({rs, b});
  endtask

  task automatic send(input logic [7:0] c);
    @(posedge clk50); #1;
    ascii_vld  = 1'b1;
    ascii_data = c;
    @(posedge clk50); #1;
    ascii_vld  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int cnt;
    cnt = 0;
    repeat (3) @(negedge clk50);
    while ((exp_q.size() != 0 || busy || lcd_vld) && cnt < 400) begin
      @(negedge clk50);
      cnt++;
    end
    check({tag, "_drain"}, cnt < 400, 1);
  endtask

  task automatic send_drain(input logic [7:0] c, input string tag);
    send(c);
    wait_drain(tag);
  endtask

  task automatic check_cursor(input string tag, input logic r, input logic [3:0] c);
    check({tag, "_row"}, cursor_row, r);
    check({tag, "_col"}, cursor_col, c);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;

    // Reset state
    repeat (3) @(negedge clk50);
    check("rst_vld", lcd_vld, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_byte", lcd_byte, 0);
    check_cursor("rst", 1'b0, 4'd0);
    check("rst_ovf", overflow, 0);

    // Initial clear
    expect_xfer(1'b0, 8'h01);
    @(posedge clk50); #1 reset = 1'b1;
    wait_drain("init");
    check("init_xfers", n_xfer, 1);
    check("init_busy", busy, 0);
    check_cursor("init", 1'b0, 4'd0);

    // Single character with latency check
    expect_xfer(1'b1, 8'h41);
    send(8'h41);
    @(negedge clk50);
    check("lat_n0_vld", lcd_vld, 0);
    @(negedge clk50);
    check("lat_n1_vld", lcd_vld, 0);
    @(negedge clk50);
    check("lat_n2_vld", lcd_vld, 1);
    check("lat_n2_word", {lcd_rs, lcd_byte}, {1'b1, 8'h41});
    wait_drain("A");
    check("A_xfers", n_xfer, 2);
    check_cursor("A", 1'b0, 4'd1);

    // Esc wipes and homes
    expect_xfer(1'b0, 8'h01);
    send_drain(8'h1B, "esc");
    check_cursor("esc", 1'b0, 4'd0);

    // Fill row 0, then a character on row 1 needs SETADDR 0xC0
    for (int i = 0; i < 16; i++) begin
      expect_xfer(1'b1, 8'h61 + 8'(i));
      send_drain(8'h61 + 8'(i), "row0");
    end
    check_cursor("row0_full", 1'b1, 4'd0);
    expect_xfer(1'b0, 8'hC0);
    expect_xfer(1'b1, 8'h5A);
    send_drain(8'h5A, "Z");
    check_cursor("Z", 1'b1, 4'd1);

    // Complete 32 characters; the next printable wipes first
    for (int i = 0; i < 14; i++) begin
      expect_xfer(1'b1, 8'h41 + 8'(i));
      send_drain(8'h41 + 8'(i), "row1");
    end
    check_cursor("row1_14", 1'b1, 4'd15);
    expect_xfer(1'b1, 8'h21);
    send_drain(8'h21, "last");
    check_cursor("screen_full", 1'b0, 4'd0);
    expect_xfer(1'b0, 8'h01);
    expect_xfer(1'b1, 8'h51);
    send_drain(8'h51, "Q");
    check_cursor("Q", 1'b0, 4'd1);

    // Enter on row 0: cursor move only
    x0 = n_xfer;
    send_drain(8'h0D, "cr0");
    check("cr0_xfers", n_xfer, x0);
    check_cursor("cr0", 1'b1, 4'd0);

    // Backspace from (1,0) to (0,15)
    expect_xfer(1'b0, 8'h8F);
    expect_xfer(1'b1, 8'h20);
    expect_xfer(1'b0, 8'h8F);
    send_drain(8'h08, "bs10");
    check_cursor("bs10", 1'b0, 4'd15);

    // Address is synced after backspace: no SETADDR before the data write
    expect_xfer(1'b1, 8'h78);
    send_drain(8'h78, "x");
    check_cursor("x", 1'b1, 4'd0);

    // Enter on row 1 arms a wipe for the next printable
    x0 = n_xfer;
    send_drain(8'h0D, "cr1");
    check("cr1_xfers", n_xfer, x0);
    check_cursor("cr1", 1'b1, 4'd0);
    expect_xfer(1'b0, 8'h01);
    expect_xfer(1'b1, 8'h79);
    send_drain(8'h79, "y");
    check_cursor("y", 1'b0, 4'd1);

    // Backspace within a row
    expect_xfer(1'b0, 8'h80);
    expect_xfer(1'b1, 8'h20);
    expect_xfer(1'b0, 8'h80);
    send_drain(8'h08, "bs01");
    check_cursor("bs01", 1'b0, 4'd0);

    // Backspace at home and an unknown control code are ignored
    x0 = n_xfer;
    send_drain(8'h08, "bs00");
    send_drain(8'h07, "bel");
    check("ignored_xfers", n_xfer, x0);
    check_cursor("ignored", 1'b0, 4'd0);
    check("pre_ovf", overflow, 0);

    // Stall the driver inside a CLEAR, then overfill the FIFO
    @(posedge clk50); #1 lcd_ready = 1'b0;
    expect_xfer(1'b0, 8'h01);
    for (int i = 0; i < 4; i++) expect_xfer(1'b1, 8'h30 + 8'(i));
    send(8'h1B);
    repeat (4) @(negedge clk50);
    check("stall_vld", lcd_vld, 1);
    check("stall_word", {lcd_rs, lcd_byte}, {1'b0, 8'h01});
    for (int i = 0; i < 6; i++) begin
      @(posedge clk50); #1;
      ascii_vld  = 1'b1;
      ascii_data = 8'h30 + 8'(i);
    end
    @(posedge clk50); #1 ascii_vld = 1'b0;
    repeat (3) @(negedge clk50);
    check("ovf_set", overflow, 1);
    check("ovf_vld", lcd_vld, 1);
    check("ovf_word", {lcd_rs, lcd_byte}, {1'b0, 8'h01});
    check("ovf_busy", busy, 1);
    x0 = n_xfer;
    @(posedge clk50); #1 lcd_ready = 1'b1;
    wait_drain("ovf");
    check("ovf_xfers", n_xfer - x0, 5);
    check("ovf_sticky", overflow, 1);
    check_cursor("ovf", 1'b0, 4'd4);

    // Reset in the middle of a stalled transfer
    @(posedge clk50); #1 lcd_ready = 1'b0;
    send(8'h55);
    repeat (3) @(negedge clk50);
    check("mid_vld", lcd_vld, 1);
    check("mid_word", {lcd_rs, lcd_byte}, {1'b1, 8'h55});
    @(posedge clk50); #1 reset = 1'b0;
    #1;
    check("mid_rst_vld", lcd_vld, 0);
    check("mid_rst_ovf", overflow, 0);
    check_cursor("mid_rst", 1'b0, 4'd0);
    expect_xfer(1'b0, 8'h01);
    @(posedge clk50); #1 lcd_ready = 1'b1;
    @(posedge clk50); #1 reset = 1'b1;
    wait_drain("restart");
    check("restart_busy", busy, 0);
    check("restart_ovf", overflow, 0);
    check_cursor("restart", 1'b0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
